// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: FSM states, master index and byte-merge helper.
package dmem_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_idx_t;

    localparam logic [3:0] BE_FULL = 4'hF;

    // Byte i comes from new_w where be[i] is set, otherwise from old_w.
    function automatic logic [31:0] merge_be(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way grant logic: round-robin with a last-winner pointer when FAIR=1, m0-first priority when FAIR=0.
module rr_arb2
    import dmem_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    master_idx_t ptr_q;
    master_idx_t ptr_d;

    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (FAIR && (ptr_q == M1)) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
        // The pointer names the master to favour next: the one that did not just win.
        if (gnt[0]) begin
            ptr_d = M1;
        end else if (gnt[1]) begin
            ptr_d = M0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= M0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of a word-addressed data memory, one transaction in flight.
// Define DMEM_ARB_RMW_EN to enable read-modify-write handling of partial byte-strobe writes.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic        m0_we,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_be,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic        m1_we,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_be,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,

    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    logic [1:0]  gnt;
    logic        arb_en;
    logic        gnt_any;
    master_idx_t sel_idx;
    logic [31:0] sel_addr;
    logic        sel_we;
    logic [31:0] sel_wdata;

    logic        rsp_valid_q, rsp_valid_d;
    master_idx_t rsp_idx_q, rsp_idx_d;
    logic [31:0] rsp_data_q, rsp_data_d;

`ifdef DMEM_ARB_RMW_EN
    state_t      state_q, state_d;
    logic [3:0]  sel_be;
    logic [31:0] rmw_addr_q, rmw_addr_d;
    logic [31:0] rmw_wdata_q, rmw_wdata_d;
    logic [3:0]  rmw_be_q, rmw_be_d;
    logic [31:0] rmw_old_q, rmw_old_d;
    master_idx_t rmw_idx_q, rmw_idx_d;

    assign arb_en = rst_n && (state_q == IDLE);
    assign sel_be = gnt[1] ? m1_be : m0_be;
`else
    logic unused_be;

    assign arb_en    = rst_n;
    assign unused_be = ^{m0_be, m1_be};
`endif

    rr_arb2 #(.FAIR(FAIR)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .req   ({m1_req, m0_req}),
        .gnt   (gnt)
    );

    assign m0_gnt    = gnt[0];
    assign m1_gnt    = gnt[1];
    assign gnt_any   = gnt[0] | gnt[1];
    assign sel_idx   = gnt[1] ? M1 : M0;
    assign sel_addr  = gnt[1] ? m1_addr  : m0_addr;
    assign sel_we    = gnt[1] ? m1_we    : m0_we;
    assign sel_wdata = gnt[1] ? m1_wdata : m0_wdata;

    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = sel_addr;
        mem_wdata   = sel_wdata;
        rsp_valid_d = 1'b0;
        rsp_idx_d   = rsp_idx_q;
        rsp_data_d  = '0;
`ifdef DMEM_ARB_RMW_EN
        state_d     = state_q;
        rmw_addr_d  = rmw_addr_q;
        rmw_wdata_d = rmw_wdata_q;
        rmw_be_d    = rmw_be_q;
        rmw_old_d   = rmw_old_q;
        rmw_idx_d   = rmw_idx_q;

        if (state_q == RMW_WR) begin
            mem_write   = 1'b1;
            mem_addr    = rmw_addr_q;
            mem_wdata   = merge_be(rmw_old_q, rmw_wdata_q, rmw_be_q);
            rsp_valid_d = 1'b1;
            rsp_idx_d   = rmw_idx_q;
            state_d     = IDLE;
        end else if (gnt_any) begin
            rsp_idx_d = sel_idx;
            if (!sel_we) begin
                mem_read    = 1'b1;
                rsp_valid_d = 1'b1;
                rsp_data_d  = mem_rdata;
            end else if (sel_be == BE_FULL) begin
                mem_write   = 1'b1;
                rsp_valid_d = 1'b1;
            end else if (sel_be == 4'h0) begin
                rsp_valid_d = 1'b1;
            end else begin
                // Partial write: fetch the old word now, write the merged word next cycle.
                mem_read    = 1'b1;
                rmw_addr_d  = sel_addr;
                rmw_wdata_d = sel_wdata;
                rmw_be_d    = sel_be;
                rmw_old_d   = mem_rdata;
                rmw_idx_d   = sel_idx;
                state_d     = RMW_WR;
            end
        end
`else
        if (gnt_any) begin
            rsp_idx_d   = sel_idx;
            rsp_valid_d = 1'b1;
            if (!sel_we) begin
                mem_read   = 1'b1;
                rsp_data_d = mem_rdata;
            end else begin
                mem_write  = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_idx_q   <= M0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_idx_q   <= rsp_idx_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

`ifdef DMEM_ARB_RMW_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rmw_addr_q  <= '0;
            rmw_wdata_q <= '0;
            rmw_be_q    <= '0;
            rmw_old_q   <= '0;
            rmw_idx_q   <= M0;
        end else begin
            state_q     <= state_d;
            rmw_addr_q  <= rmw_addr_d;
            rmw_wdata_q <= rmw_wdata_d;
            rmw_be_q    <= rmw_be_d;
            rmw_old_q   <= rmw_old_d;
            rmw_idx_q   <= rmw_idx_d;
        end
    end
`endif

    assign m0_rvalid = rsp_valid_q && (rsp_idx_q == M0);
    assign m1_rvalid = rsp_valid_q && (rsp_idx_q == M1);
    assign m0_rdata  = m0_rvalid ? rsp_data_q : '0;
    assign m1_rdata  = m1_rvalid ? rsp_data_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (FAIR=1 instance with memory model, FAIR=0 instance for grants).
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [3:0]  m0_be = 4'hF, m1_be = 4'hF;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        f_m0_gnt, f_m1_gnt, f_m0_rvalid, f_m1_rvalid;
    logic [31:0] f_m0_rdata, f_m1_rdata;
    logic        f_mem_read, f_mem_write;
    logic [31:0] f_mem_addr, f_mem_wdata;

    logic [31:0] mem [0:63];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_idx] <= pre_val;
        end else if (mem_write) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    dmem_arbiter #(.FAIR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata), .m0_be(m0_be),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata), .m1_be(m1_be),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.FAIR(1'b0)) dut_fixed (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata), .m0_be(m0_be),
        .m0_gnt(f_m0_gnt), .m0_rvalid(f_m0_rvalid), .m0_rdata(f_m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata), .m1_be(m1_be),
        .m1_gnt(f_m1_gnt), .m1_rvalid(f_m1_rvalid), .m1_rdata(f_m1_rdata),
        .mem_read(f_mem_read), .mem_write(f_mem_write), .mem_addr(f_mem_addr),
        .mem_wdata(f_mem_wdata), .mem_rdata(32'h0)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
        m0_be = 4'hF;  m1_be = 4'hF;
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        pre_en = 1'b1; pre_idx = idx; pre_val = val;
        next_cycle();
        pre_en = 1'b0;
    endtask

    task automatic pulse_reset();
        idle_inputs();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; m0_req = 1'b1; m1_req = 1'b1;
        #2;
        checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin errors++; $display("[TB] FAIL reset_gnt: got %b expected 00", {m0_gnt, m1_gnt}); end
        checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("[TB] FAIL reset_rvalid: got %b expected 00", {m0_rvalid, m1_rvalid}); end
        checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("[TB] FAIL reset_mem_strobes: got %b expected 00", {mem_read, mem_write}); end
        checks++; if ((m0_rdata | m1_rdata) !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h/%h expected 0", m0_rdata, m1_rdata); end
        idle_inputs();
        @(negedge clk); rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_read();
        preload(6'd4, 32'hDEADBEEF);
        m0_req = 1'b1; m0_addr = 32'h10; m0_we = 1'b0;
        @(negedge clk);
        checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("[TB] FAIL read_gnt: got m0=%b m1=%b expected m0=1 m1=0", m0_gnt, m1_gnt); end
        checks++; if ({mem_read, mem_write} !== 2'b10) begin errors++; $display("[TB] FAIL read_strobes: got rd=%b wr=%b expected rd=1 wr=0", mem_read, mem_write); end
        checks++; if (mem_addr !== 32'h10) begin errors++; $display("[TB] FAIL read_addr: got %h expected 00000010", mem_addr); end
        next_cycle();
        m0_req = 1'b0;
        @(negedge clk);
        checks++; if ({m0_rvalid, m1_rvalid} !== 2'b10) begin errors++; $display("[TB] FAIL read_rvalid: got m0=%b m1=%b expected m0=1 m1=0", m0_rvalid, m1_rvalid); end
        checks++; if (m0_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL read_rdata: got %h expected deadbeef", m0_rdata); end
        checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("[TB] FAIL read_idle_strobes: got %b expected 00", {mem_read, mem_write}); end
        next_cycle();
        m1_req = 1'b1; m1_addr = 32'h13; m1_we = 1'b0;
        @(negedge clk);
        checks++; if ({m0_gnt, m1_gnt} !== 2'b01) begin errors++; $display("[TB] FAIL unaligned_gnt: got m0=%b m1=%b expected m0=0 m1=1", m0_gnt, m1_gnt); end
        checks++; if (mem_addr !== 32'h13) begin errors++; $display("[TB] FAIL unaligned_addr: got %h expected 00000013", mem_addr); end
        next_cycle();
        m1_req = 1'b0;
        @(negedge clk);
        checks++; if ({m0_rvalid, m1_rvalid} !== 2'b01) begin errors++; $display("[TB] FAIL unaligned_rvalid: got m0=%b m1=%b expected m0=0 m1=1", m0_rvalid, m1_rvalid); end
        checks++; if (m1_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL unaligned_rdata: got %h expected deadbeef", m1_rdata); end
        next_cycle();
    endtask

    task automatic test_fairness();
        int          exp_win [4];
        logic [31:0] exp_data [2];
        int          prev;
        exp_win = '{0, 1, 0, 1};
        exp_data = '{32'h0000A0A0, 32'h0000B1B1};
        pulse_reset();
        preload(6'd2, 32'h0000A0A0);
        preload(6'd3, 32'h0000B1B1);
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            m0_req = (k < 4); m0_addr = 32'h08; m0_we = 1'b0;
            m1_req = (k < 4); m1_addr = 32'h0C; m1_we = 1'b0;
            @(negedge clk);
            if (k < 4) begin
                checks++; if ({m0_gnt, m1_gnt} !== {exp_win[k] == 0, exp_win[k] == 1}) begin errors++; $display("[TB] FAIL fair_gnt[%0d]: got m0=%b m1=%b expected winner m%0d", k, m0_gnt, m1_gnt, exp_win[k]); end
                checks++; if ({f_m0_gnt, f_m1_gnt} !== 2'b10) begin errors++; $display("[TB] FAIL fixed_gnt[%0d]: got m0=%b m1=%b expected m0=1 m1=0", k, f_m0_gnt, f_m1_gnt); end
            end
            if (k > 0) begin
                checks++; if ({m0_rvalid, m1_rvalid} !== {prev == 0, prev == 1}) begin errors++; $display("[TB] FAIL fair_rvalid[%0d]: got m0=%b m1=%b expected m%0d", k, m0_rvalid, m1_rvalid, prev); end
                checks++; if ((m0_rdata | m1_rdata) !== exp_data[prev]) begin errors++; $display("[TB] FAIL fair_rdata[%0d]: got %h expected %h", k, m0_rdata | m1_rdata, exp_data[prev]); end
            end
            if (k < 4) prev = exp_win[k];
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        m0_req = 1'b1; m0_addr = 32'h20; m0_we = 1'b1; m0_wdata = 32'h5; m0_be = 4'hF;
        @(negedge clk);
        checks++; if ({mem_read, mem_write} !== 2'b01) begin errors++; $display("[TB] FAIL b2b_write_strobes: got rd=%b wr=%b expected rd=0 wr=1", mem_read, mem_write); end
        checks++; if (mem_wdata !== 32'h5 || mem_addr !== 32'h20) begin errors++; $display("[TB] FAIL b2b_write_bus: got addr=%h data=%h expected addr=00000020 data=00000005", mem_addr, mem_wdata); end
        next_cycle();
        m0_we = 1'b0;
        @(negedge clk);
        checks++; if ({m0_gnt, mem_read, mem_write} !== 3'b110) begin errors++; $display("[TB] FAIL b2b_read_issue: got gnt=%b rd=%b wr=%b expected gnt=1 rd=1 wr=0", m0_gnt, mem_read, mem_write); end
        checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h0) begin errors++; $display("[TB] FAIL b2b_write_ack: got rvalid=%b rdata=%h expected rvalid=1 rdata=0", m0_rvalid, m0_rdata); end
        next_cycle();
        m0_req = 1'b0;
        @(negedge clk);
        checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h5) begin errors++; $display("[TB] FAIL b2b_read_data: got rvalid=%b rdata=%h expected rvalid=1 rdata=00000005", m0_rvalid, m0_rdata); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_byte_enables();
        preload(6'd12, 32'h77777777);
        m0_req = 1'b1; m0_addr = 32'h30; m0_we = 1'b1;
`ifdef DMEM_ARB_RMW_EN
        m0_be = 4'h0; m0_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        checks++; if ({m0_gnt, mem_read, mem_write} !== 3'b100) begin errors++; $display("[TB] FAIL be0_strobes: got gnt=%b rd=%b wr=%b expected gnt=1 rd=0 wr=0", m0_gnt, mem_read, mem_write); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h0) begin errors++; $display("[TB] FAIL be0_ack: got rvalid=%b rdata=%h expected rvalid=1 rdata=0", m0_rvalid, m0_rdata); end
        checks++; if (mem[12] !== 32'h77777777) begin errors++; $display("[TB] FAIL be0_mem: got %h expected 77777777", mem[12]); end
`else
        m0_be = 4'b0001; m0_wdata = 32'hCAFEF00D;
        @(negedge clk);
        checks++; if ({m0_gnt, mem_read, mem_write} !== 3'b101) begin errors++; $display("[TB] FAIL be1_strobes: got gnt=%b rd=%b wr=%b expected gnt=1 rd=0 wr=1", m0_gnt, mem_read, mem_write); end
        checks++; if (mem_wdata !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL be1_wdata: got %h expected cafef00d", mem_wdata); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++; if (m0_rvalid !== 1'b1) begin errors++; $display("[TB] FAIL be1_ack: got %b expected 1", m0_rvalid); end
        checks++; if (mem[12] !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL be1_mem: got %h expected cafef00d", mem[12]); end
`endif
        next_cycle();
    endtask

`ifdef DMEM_ARB_RMW_EN
    task automatic test_rmw();
        preload(6'd16, 32'h11223344);
        m1_req = 1'b1; m1_addr = 32'h40; m1_we = 1'b1; m1_be = 4'b0010; m1_wdata = 32'hAABBCCDD;
        @(negedge clk);
        checks++; if ({m1_gnt, mem_read, mem_write} !== 3'b110) begin errors++; $display("[TB] FAIL rmw_c0: got gnt=%b rd=%b wr=%b expected gnt=1 rd=1 wr=0", m1_gnt, mem_read, mem_write); end
        next_cycle();
        m1_req = 1'b0; m0_req = 1'b1; m0_addr = 32'h10; m0_we = 1'b0;
        @(negedge clk);
        checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin errors++; $display("[TB] FAIL rmw_c1_gnt: got m0=%b m1=%b expected 00", m0_gnt, m1_gnt); end
        checks++; if ({mem_read, mem_write} !== 2'b01) begin errors++; $display("[TB] FAIL rmw_c1_strobes: got rd=%b wr=%b expected rd=0 wr=1", mem_read, mem_write); end
        checks++; if (mem_wdata !== 32'h1122CC44 || mem_addr !== 32'h40) begin errors++; $display("[TB] FAIL rmw_c1_bus: got addr=%h data=%h expected addr=00000040 data=1122cc44", mem_addr, mem_wdata); end
        checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("[TB] FAIL rmw_c1_rvalid: got %b expected 00", {m0_rvalid, m1_rvalid}); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++; if ({m0_rvalid, m1_rvalid} !== 2'b01 || m1_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rmw_c2_ack: got m0=%b m1=%b rdata=%h expected m1 only, rdata 0", m0_rvalid, m1_rvalid, m1_rdata); end
        checks++; if (mem[16] !== 32'h1122CC44) begin errors++; $display("[TB] FAIL rmw_mem: got %h expected 1122cc44", mem[16]); end
        next_cycle();
    endtask
`endif

    task automatic test_reset_abort();
`ifdef DMEM_ARB_RMW_EN
        preload(6'd20, 32'h12345678);
        m0_req = 1'b1; m0_addr = 32'h50; m0_we = 1'b1; m0_be = 4'b0001; m0_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        checks++; if ({m0_gnt, mem_read} !== 2'b11) begin errors++; $display("[TB] FAIL abort_c0: got gnt=%b rd=%b expected 11", m0_gnt, mem_read); end
        next_cycle();
        m0_req = 1'b1; m0_we = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if ({mem_read, mem_write, m0_gnt, m1_gnt} !== 4'b0000) begin errors++; $display("[TB] FAIL abort_outputs: got rd=%b wr=%b gnt=%b%b expected all 0", mem_read, mem_write, m0_gnt, m1_gnt); end
        idle_inputs();
        @(negedge clk);
        checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("[TB] FAIL abort_rvalid: got %b expected 00", {m0_rvalid, m1_rvalid}); end
        checks++; if (mem[20] !== 32'h12345678) begin errors++; $display("[TB] FAIL abort_mem: got %h expected 12345678", mem[20]); end
`else
        m0_req = 1'b1; m0_addr = 32'h10; m0_we = 1'b0;
        @(negedge clk);
        checks++; if ({m0_gnt, mem_read} !== 2'b11) begin errors++; $display("[TB] FAIL abort_c0: got gnt=%b rd=%b expected 11", m0_gnt, mem_read); end
        rst_n = 1'b0;
        idle_inputs();
        next_cycle();
        checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("[TB] FAIL abort_rvalid: got %b expected 00", {m0_rvalid, m1_rvalid}); end
        checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("[TB] FAIL abort_strobes: got %b expected 00", {mem_read, mem_write}); end
        @(negedge clk);
`endif
        rst_n = 1'b1;
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        test_reset();
        test_read();
        test_fairness();
        test_back_to_back();
        test_byte_enables();
`ifdef DMEM_ARB_RMW_EN
        test_rmw();
`endif
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 FAIR, 1: 1 = round-robin between masters; 0 = fixed priority, m0 always wins.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 m0_req / m1_req  input  1  master request (m0 = CPU load/store unit, m1 = DMA/debug port).
REQ-005 mX_addr  input  32  byte address; mX_we input 1 write select; mX_wdata input 32 store data; mX_be input 4 byte strobes, bit i = byte i.
REQ-006 mX_gnt  output  1  request accepted this cycle (combinational from req and arbiter state).
REQ-007 mX_rvalid  output  1  one-cycle response pulse; mX_rdata output 32 load data, 0 for write acks.
REQ-008 mem_read / mem_write  output  1  strobes to the word-addressed data memory (write on posedge, combinational read).
REQ-009 mem_addr  output  32; mem_wdata output 32; mem_rdata input 32 (combinational read data).

Function
REQ-010 FSM states: IDLE, RMW_WR; at most one transaction in flight.
REQ-011 IDLE: transaction accepted on a cycle with mX_req && mX_gnt; at most one mX_gnt high per cycle.
REQ-012 Grant is 0 for both masters in RMW_WR and in the cycle a response is still pending from a prior RMW.
REQ-013 FAIR=1: single requester always granted; both requesting -> grant the master not granted last; pointer favours m0 after reset.
REQ-014 FAIR=0: both requesting -> m0 granted; m1 granted only when m0_req=0.
REQ-015 Read (we=0): mem_read=1, mem_addr=mX_addr in the grant cycle; mem_rdata registered; mX_rvalid=1 with that data next cycle.
REQ-016 Full-word write (we=1, be=4'hF): mem_write=1, mem_wdata=mX_wdata in grant cycle; mX_rvalid=1, mX_rdata=0 next cycle.
REQ-017 Write with be=4'h0: no memory access; ack (rvalid) next cycle.
REQ-018 mem_read and mem_write are never both 1; both 0 when no transaction is active.
REQ-019 Response is routed only to the master granted; the other master's rvalid stays 0.
REQ-020 Address low bits [1:0] passed through unchanged; alignment not checked.
REQ-021 New grant is allowed in the same cycle as a response pulse (back-to-back throughput 1 transaction/cycle for reads and full writes).

Reset
REQ-022 rst_n=0: state IDLE, RR pointer = m0 preferred, all gnt/rvalid/mem strobes 0, rdata registers 0.
REQ-023 Reset mid-RMW aborts: no memory write issued, no rvalid produced.

Configuration
REQ-024 Macro DMEM_ARB_RMW_EN defined: partial write (be not 4'hF and not 4'h0) = grant cycle mem_read, latch addr/wdata/be/old word -> RMW_WR cycle mem_write of merged word (byte i from wdata if be[i], else old) -> rvalid next cycle; 3-cycle latency.
REQ-025 Macro undefined: mX_be ignored except REQ-017 not applied; every write is a full-word write per REQ-016; RMW_WR state absent.

Structure
REQ-026 Shared package dmem_pkg: FSM state enum, master-index type, BE_FULL = 4'hF constant.
REQ-027 One sub-module rr_arb2 (2-way round-robin/fixed-priority grant with pointer) is natural; merge logic stays inline.

Verification
REQ-028 m0 read addr 0x10 with mem word 0xDEADBEEF -> m0_gnt cycle 0, m0_rvalid cycle 1, m0_rdata=0xDEADBEEF.
REQ-029 FAIR=1, both masters request reads continuously -> grants alternate m0,m1,m0,m1; FAIR=0 -> m0 every cycle.
REQ-030 RMW_EN: word 0x11223344, m1 write be=4'b0010 wdata=0xAABBCCDD -> memory becomes 0x1122CC44, m1_rvalid cycle 2, no grants in cycle 1.
REQ-031 Write be=0 -> no mem_write pulse, ack next cycle; without RMW_EN, be=4'b0001 write stores full wdata.
REQ-032 rst_n asserted during RMW_WR -> memory unchanged, no rvalid, outputs 0 immediately.
REQ-033 Full-word write 0x5 to 0x20 then read 0x20 back-to-back -> read returns 0x5, never mem_read and mem_write together.
